// File: rtl/div_axis_core.sv
// div_axis_core: iterative 32-bit divider with two AXI-Stream style operand
// channels and one result channel (no backpressure on the result).
//
// Ports
//   clk                     single clock, all state on posedge
//   rst                     synchronous active-high reset
//   s_axis_divisor_tdata    [31:0] divisor operand
//   s_axis_divisor_tvalid   divisor valid
//   s_axis_divisor_tready   divisor ready (IDLE and not yet captured)
//   s_axis_dividend_tdata   [31:0] dividend operand
//   s_axis_dividend_tvalid  dividend valid
//   s_axis_dividend_tready  dividend ready (IDLE and not yet captured)
//   m_axis_dout_tdata       [63:32] quotient, [31:0] remainder
//   m_axis_dout_tvalid      one-cycle pulse in DONE
//
// Parameter SIGNED: 1 = two's-complement divide (quotient truncated toward
// zero, remainder takes the dividend's sign), 0 = unsigned divide.
//
// Build option: define DIV_RADIX4_EN to retire two quotient bits per CALC
// cycle (16 CALC cycles instead of 32). Results are identical in both builds.
//
// Divide by zero falls out of the restoring algorithm: every trial subtract
// succeeds, giving raw quotient 0xFFFFFFFF and remainder |dividend| before
// the sign fix.

module div_axis_core #(
  parameter int SIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  output logic [63:0] m_axis_dout_tdata,
  output logic        m_axis_dout_tvalid
);

  typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

`ifdef DIV_RADIX4_EN
  localparam int unsigned STEPS = 2;
`else
  localparam int unsigned STEPS = 1;
`endif
  localparam int unsigned LAST = 32 / STEPS - 1;
  localparam logic [4:0]  CNT_LAST = 5'(LAST);

  state_t      state_q, state_d;
  logic        dvs_cap_q, dvs_cap_d;
  logic        dvd_cap_q, dvd_cap_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [63:0] dout_q, dout_d;
  logic        valid_q, valid_d;

  logic        dvs_rdy, dvd_rdy, dvs_hs, dvd_hs;
  logic        dvs_neg, dvd_neg;
  logic [32:0] rem_t, trial;
  logic [31:0] quo_t, q_fin, r_fin;

  assign dvs_rdy = (state_q == IDLE) && !dvs_cap_q && !rst;
  assign dvd_rdy = (state_q == IDLE) && !dvd_cap_q && !rst;
  assign dvs_hs  = s_axis_divisor_tvalid  && dvs_rdy;
  assign dvd_hs  = s_axis_dividend_tvalid && dvd_rdy;

  assign s_axis_divisor_tready  = dvs_rdy;
  assign s_axis_dividend_tready = dvd_rdy;
  assign m_axis_dout_tdata      = dout_q;
  assign m_axis_dout_tvalid     = valid_q;

  assign dvs_neg = (SIGNED != 0) && dvs_q[31];
  assign dvd_neg = (SIGNED != 0) && dvd_q[31];

  // Restoring steps for one CALC cycle. quo holds the magnitude of the
  // dividend, shifted out MSB-first while quotient bits shift in at the LSB.
  // The trial value is 33 bits so the compare/subtract never overflows.
  always_comb begin
    rem_t = rem_q;
    quo_t = quo_q;
    trial = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      trial = {rem_t[31:0], quo_t[31]};
      if (trial >= {1'b0, dvs_q}) begin
        rem_t = trial - {1'b0, dvs_q};
        quo_t = {quo_t[30:0], 1'b1};
      end else begin
        rem_t = trial;
        quo_t = {quo_t[30:0], 1'b0};
      end
    end
    q_fin = negq_q ? (32'd0 - quo_t) : quo_t;
    r_fin = negr_q ? (32'd0 - rem_t[31:0]) : rem_t[31:0];
  end

  always_comb begin
    state_d   = state_q;
    dvs_cap_d = dvs_cap_q;
    dvd_cap_d = dvd_cap_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dvs_hs) begin
          dvs_cap_d = 1'b1;
          dvs_d     = s_axis_divisor_tdata;
        end
        if (dvd_hs) begin
          dvd_cap_d = 1'b1;
          dvd_d     = s_axis_dividend_tdata;
        end
        if ((dvs_cap_q || dvs_hs) && (dvd_cap_q || dvd_hs)) state_d = PREP;
      end
      PREP: begin
        // Divisor register is reused for its magnitude; signs live in flags.
        negq_d  = dvs_neg ^ dvd_neg;
        negr_d  = dvd_neg;
        dvs_d   = dvs_neg ? (32'd0 - dvs_q) : dvs_q;
        quo_d   = dvd_neg ? (32'd0 - dvd_q) : dvd_q;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        rem_d = rem_t;
        quo_d = quo_t;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          dout_d  = {q_fin, r_fin};
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        dvs_cap_d = 1'b0;
        dvd_cap_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dvs_cap_q <= 1'b0;
      dvd_cap_q <= 1'b0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvs_cap_q <= dvs_cap_d;
      dvd_cap_q <= dvd_cap_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_div_axis_core.sv
// Bench for div_axis_core: a signed and an unsigned instance share all
// stimulus; results are compared against an arithmetic reference model.

module tb_div_axis_core;

`ifdef DIV_RADIX4_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dvs_data, dvd_data;
  logic        dvs_valid, dvd_valid;
  logic        dvs_ready, dvd_ready, dvs_ready_u, dvd_ready_u;
  logic [63:0] dout, dout_u;
  logic        tvalid, tvalid_u;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_axis_core #(.SIGNED(1)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_divisor_tdata   (dvs_data),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tready  (dvs_ready),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tready (dvd_ready),
    .m_axis_dout_tdata      (dout),
    .m_axis_dout_tvalid     (tvalid)
  );

  div_axis_core #(.SIGNED(0)) dut_u (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_divisor_tdata   (dvs_data),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tready  (dvs_ready_u),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tready (dvd_ready_u),
    .m_axis_dout_tdata      (dout_u),
    .m_axis_dout_tvalid     (tvalid_u)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: quotient/remainder from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      if (sgn && $signed(a) < 0) return {32'h0000_0001, a};
      return {32'hFFFF_FFFF, a};
    end
    if (!sgn) return {a / b, a % b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  // Cycle boundary: inputs are driven right after this, outputs sampled #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ready(input string tag, input logic exp);
    check_eq(tag, {62'd0, dvs_ready, dvd_ready}, {62'd0, exp, exp});
    check_eq({tag, "_u"}, {62'd0, dvs_ready_u, dvd_ready_u}, {62'd0, exp, exp});
  endtask

  // Called after cycle 0 sampling; follows cycles 1..LAT+4 with valids low.
  task automatic wait_result(input string tag, input logic [63:0] exp_s, input logic [63:0] exp_u);
    int pulses = 0;
    int first  = -1;
    logic [63:0] got_s = '0, got_u = '0;
    for (int cyc = 1; cyc <= LAT + 4; cyc++) begin
      tick();
      dvs_valid = 1'b0;
      dvd_valid = 1'b0;
      #1;
      if (cyc == 1) check_ready({tag, "_busy_rdy"}, 1'b0);
      if (tvalid) begin
        pulses++;
        if (first < 0) begin
          first = cyc;
          got_s = dout;
          got_u = dout_u;
        end
      end
    end
    check_eq({tag, "_pulses"}, 64'(pulses), 64'd1);
    check_eq({tag, "_cycle"}, 64'(first), 64'(LAT));
    check_eq({tag, "_s"}, got_s, exp_s);
    check_eq({tag, "_u"}, got_u, exp_u);
    check_eq({tag, "_hold"}, dout, got_s);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_s, input logic [63:0] exp_u);
    tick();
    dvd_data  = a;
    dvs_data  = b;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    #1;
    check_ready({tag, "_rdy"}, 1'b1);
    wait_result(tag, exp_s, exp_u);
  endtask

  initial begin
    int acc_n, np;
    int acc_cyc[2];
    int p_cyc[4];
    logic [63:0] p_dat[4];
    logic [31:0] ops_a[2], ops_b[2];
    logic [31:0] ra, rb;
    int pulses;

    rst = 1'b1;
    dvs_data = '0; dvd_data = '0; dvs_valid = 1'b0; dvd_valid = 1'b0;
    repeat (3) tick();
    dvs_valid = 1'b1; dvd_valid = 1'b1;
    #1;
    check_ready("rst_rdy", 1'b0);
    check_eq("rst_tvalid", {62'd0, tvalid, tvalid_u}, 64'd0);
    check_eq("rst_tdata", dout, 64'd0);
    check_eq("rst_tdata_u", dout_u, 64'd0);
    dvs_valid = 1'b0; dvd_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_ready("post_rst_rdy", 1'b1);

    // Directed cases.
    run_op("u100_7", 32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002);
    run_op("s_m7_2", 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, model(32'hFFFFFFF9, 32'd2, 1'b0));
    run_op("s_ovf", 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 64'h00000000_80000000);
    run_op("dz_5", 32'd5, 32'd0, 64'hFFFFFFFF_00000005, 64'hFFFFFFFF_00000005);
    run_op("dz_m5", 32'hFFFFFFFB, 32'd0, 64'h00000001_FFFFFFFB, 64'hFFFFFFFF_FFFFFFFB);

    // Divisor captured three cycles before the dividend; later divisor data ignored.
    tick();
    dvs_data = 32'd3; dvs_valid = 1'b1;
    #1;
    check_eq("early_dvs_rdy", {63'd0, dvs_ready}, 64'd1);
    tick();
    dvs_valid = 1'b0; dvs_data = 32'd77;
    #1;
    check_eq("early_dvs_low_m2", {63'd0, dvs_ready}, 64'd0);
    check_eq("early_dvd_high_m2", {63'd0, dvd_ready}, 64'd1);
    tick();
    dvs_valid = 1'b1;
    #1;
    check_eq("early_dvs_low_m1", {63'd0, dvs_ready}, 64'd0);
    tick();
    dvs_valid = 1'b1; dvs_data = 32'd55;
    dvd_data = 32'd9; dvd_valid = 1'b1;
    #1;
    check_eq("early_dvd_rdy", {63'd0, dvd_ready}, 64'd1);
    wait_result("early", 64'h00000003_00000000, 64'h00000003_00000000);

    // Reset during CALC step 10 (cycle 12) abandons the operation.
    tick();
    dvd_data = 32'd100; dvs_data = 32'd7; dvd_valid = 1'b1; dvs_valid = 1'b1;
    #1;
    pulses = 0;
    for (int cyc = 1; cyc <= LAT + 8; cyc++) begin
      tick();
      dvd_valid = 1'b0; dvs_valid = 1'b0;
      rst = (cyc == 12);
      #1;
      if (tvalid || tvalid_u) pulses++;
      if (cyc == 12) check_ready("midrst_rdy_low", 1'b0);
      if (cyc == 13) check_ready("midrst_rdy_high", 1'b1);
    end
    check_eq("midrst_pulses", 64'(pulses), 64'd0);
    run_op("after_rst", 32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002);

    // Back-to-back with valids held high.
    ops_a[0] = 32'd100;            ops_b[0] = 32'd7;
    ops_a[1] = $urandom;           ops_b[1] = $urandom_range(1, 5000);
    acc_n = 0; np = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1;
    for (int cyc = 0; cyc <= 2 * LAT + 6; cyc++) begin
      tick();
      if (acc_n < 2) begin
        dvd_data = ops_a[acc_n]; dvs_data = ops_b[acc_n];
        dvd_valid = 1'b1; dvs_valid = 1'b1;
      end else begin
        dvd_valid = 1'b0; dvs_valid = 1'b0;
      end
      #1;
      if (dvd_valid && dvs_valid && dvd_ready && dvs_ready) begin
        acc_cyc[acc_n] = cyc;
        acc_n++;
      end
      if (tvalid && np < 4) begin
        p_cyc[np] = cyc;
        p_dat[np] = dout;
        np++;
      end
    end
    check_eq("b2b_acc0", 64'(acc_cyc[0]), 64'd0);
    check_eq("b2b_acc1", 64'(acc_cyc[1]), 64'(LAT + 1));
    check_eq("b2b_pulses", 64'(np), 64'd2);
    if (np == 2) begin
      check_eq("b2b_p0_cyc", 64'(p_cyc[0]), 64'(LAT));
      check_eq("b2b_p1_cyc", 64'(p_cyc[1]), 64'(2 * LAT + 1));
      check_eq("b2b_p0_dat", p_dat[0], model(ops_a[0], ops_b[0], 1'b1));
      check_eq("b2b_p1_dat", p_dat[1], model(ops_a[1], ops_b[1], 1'b1));
    end

    // Randomized operands with biased corner values.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0: ra = $urandom_range(0, 1000);
        1: ra = 32'h80000000;
        2: ra = 32'd0 - $urandom_range(1, 1000);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = $urandom_range(1, 20);
        3: rb = 32'd0 - $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op("rand", ra, rb, model(ra, rb, 1'b1), model(ra, rb, 1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
